// File: rtl/gate_tt_sequencer.sv
// Truth-table self-check sequencer for a 2-input gate: walks {a,b} through 00..11, samples y, counts mismatches.
// Optional first-error log is built when GATE_SEQ_ERRLOG_EN is defined.
module gate_tt_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [3:0]       exp_tt_i,
    input  logic             y_i,
    output logic             a_o,
    output logic             b_o,
    output logic [1:0]       vec_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o
`ifdef GATE_SEQ_ERRLOG_EN
    ,
    output logic             first_err_vld_o,
    output logic [1:0]       first_err_idx_o
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         vec_q, vec_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic [3:0]         tt_q, tt_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               feVld_q, feVld_d;
    logic [1:0]         feIdx_q, feIdx_d;

    logic               sampleMiss;
    logic [CNT_W-1:0]   errSampled;

    // Saturating count including the compare happening this cycle.
    assign sampleMiss = (y_i != tt_q[vec_q]);
    assign errSampled = (sampleMiss && (err_q != ERR_MAX)) ? (err_q + 1'b1) : err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            vec_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            tt_q    <= 4'd0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            feVld_q <= 1'b0;
            feIdx_q <= 2'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            feVld_q <= feVld_d;
            feIdx_q <= feIdx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        a_d     = a_q;
        b_d     = b_q;
        tt_d    = tt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        feVld_d = feVld_q;
        feIdx_d = feIdx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tt_d    = exp_tt_i;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                    feVld_d = 1'b0;
                    feIdx_d = 2'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                err_d = errSampled;
                if (sampleMiss && !feVld_q) begin
                    feVld_d = 1'b1;
                    feIdx_d = vec_q;
                end
                if (vec_q != 2'd3) begin
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_q + 2'd1;
                    hold_d     = HOLD_LOAD;
                    state_d    = ST_SETTLE;
                end else begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errSampled == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign vec_idx_o = vec_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;

`ifdef GATE_SEQ_ERRLOG_EN
    assign first_err_vld_o = feVld_q;
    assign first_err_idx_o = feIdx_q;
`else
    logic unusedFe;
    assign unusedFe = feVld_q ^ (^feIdx_q);
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: default, CNT_W=1 and HOLD_CYCLES=1 instances share clock and reset.
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       start01 = 1'b0;
    logic       start2 = 1'b0;
    logic [3:0] expTt = 4'b0111;
    int         yMode = 0;

    logic       a0, b0, busy0, done0, pass0, y0;
    logic [1:0] vec0;
    logic [2:0] err0;
    logic       a1, b1, busy1, done1, pass1, y1;
    logic [1:0] vec1;
    logic [0:0] err1;
    logic       a2, b2, busy2, done2, pass2, y2;
    logic [1:0] vec2;
    logic [2:0] err2;
`ifdef GATE_SEQ_ERRLOG_EN
    logic       feVld0, feVld1, feVld2;
    logic [1:0] feIdx0, feIdx1, feIdx2;
`endif

    int checks = 0;
    int errors = 0;
    int doneCnt0 = 0;
    int baseCnt = 0;

    // Gate models: 0 = NAND, 1 = AND, 2 = output stuck at 1.
    function automatic logic gateModel(input int mode, input logic a, input logic b);
        case (mode)
            0:       return ~(a & b);
            1:       return a & b;
            default: return 1'b1;
        endcase
    endfunction

    assign y0 = gateModel(yMode, a0, b0);
    assign y1 = gateModel(yMode, a1, b1);
    assign y2 = ~(a2 & b2);

    gate_tt_sequencer #(.HOLD_CYCLES(4), .CNT_W(3)) dut0 (
        .clk_i(clk), .rst_n_i(rstN), .start_i(start01), .exp_tt_i(expTt), .y_i(y0),
        .a_o(a0), .b_o(b0), .vec_idx_o(vec0), .busy_o(busy0), .done_o(done0),
        .pass_o(pass0), .err_cnt_o(err0)
`ifdef GATE_SEQ_ERRLOG_EN
        , .first_err_vld_o(feVld0), .first_err_idx_o(feIdx0)
`endif
    );

    gate_tt_sequencer #(.HOLD_CYCLES(4), .CNT_W(1)) dut1 (
        .clk_i(clk), .rst_n_i(rstN), .start_i(start01), .exp_tt_i(expTt), .y_i(y1),
        .a_o(a1), .b_o(b1), .vec_idx_o(vec1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .err_cnt_o(err1)
`ifdef GATE_SEQ_ERRLOG_EN
        , .first_err_vld_o(feVld1), .first_err_idx_o(feIdx1)
`endif
    );

    gate_tt_sequencer #(.HOLD_CYCLES(1), .CNT_W(3)) dut2 (
        .clk_i(clk), .rst_n_i(rstN), .start_i(start2), .exp_tt_i(4'b0111), .y_i(y2),
        .a_o(a2), .b_o(b2), .vec_idx_o(vec2), .busy_o(busy2), .done_o(done2),
        .pass_o(pass2), .err_cnt_o(err2)
`ifdef GATE_SEQ_ERRLOG_EN
        , .first_err_vld_o(feVld2), .first_err_idx_o(feIdx2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done0 === 1'b1) doneCnt0++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise the selected start, let one edge accept it, then drop it; returns 1 time unit after edge 0.
    task automatic applyStimulus(input int sel);
        if (sel == 2) start2 = 1'b1; else start01 = 1'b1;
        tick(1);
        if (sel == 2) start2 = 1'b0; else start01 = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_a", 8'(a0), 8'd0);
        checkOutput("rst_b", 8'(b0), 8'd0);
        checkOutput("rst_vec", 8'(vec0), 8'd0);
        checkOutput("rst_busy", 8'(busy0), 8'd0);
        checkOutput("rst_done", 8'(done0), 8'd0);
        checkOutput("rst_pass", 8'(pass0), 8'd0);
        checkOutput("rst_err", 8'(err0), 8'd0);
        @(negedge clk) rstN = 1'b1;
        tick(2);

        $display("[TB] test 1: NAND with matching table");
        baseCnt = doneCnt0;
        applyStimulus(0);
        checkOutput("t1_busy_e0", 8'(busy0), 8'd1);
        checkOutput("t1_ab_e0", 8'({a0, b0}), 8'd0);
        tick(4);
        checkOutput("t1_ab_e4", 8'({a0, b0}), 8'd0);
        tick(1);
        checkOutput("t1_ab_e5", 8'({a0, b0}), 8'd1);
        checkOutput("t1_vec_e5", 8'(vec0), 8'd1);
        tick(5);
        checkOutput("t1_ab_e10", 8'({a0, b0}), 8'd2);
        tick(5);
        checkOutput("t1_ab_e15", 8'({a0, b0}), 8'd3);
        checkOutput("t1_vec_e15", 8'(vec0), 8'd3);
        tick(4);
        checkOutput("t1_busy_e19", 8'(busy0), 8'd1);
        checkOutput("t1_done_e19", 8'(done0), 8'd0);
        tick(1);
        checkOutput("t1_done_e20", 8'(done0), 8'd1);
        checkOutput("t1_busy_e20", 8'(busy0), 8'd0);
        checkOutput("t1_pass", 8'(pass0), 8'd1);
        checkOutput("t1_err", 8'(err0), 8'd0);
        checkOutput("t1_ab_done", 8'({a0, b0}), 8'd0);
        checkOutput("t1_pass_w1", 8'(pass1), 8'd1);
`ifdef GATE_SEQ_ERRLOG_EN
        checkOutput("t1_fe_vld", 8'(feVld0), 8'd0);
`endif
        tick(1);
        checkOutput("t1_done_e21", 8'(done0), 8'd0);
        checkOutput("t1_pass_hold", 8'(pass0), 8'd1);
        checkOutput("t1_done_count", 8'(doneCnt0 - baseCnt), 8'd1);

        $display("[TB] test 2: AND gate against NAND table");
        yMode = 1;
        applyStimulus(0);
        checkOutput("t2_pass_clr", 8'(pass0), 8'd0);
        tick(19);
        checkOutput("t2_err_e19", 8'(err0), 8'd3);
        tick(1);
        checkOutput("t2_done", 8'(done0), 8'd1);
        checkOutput("t2_err", 8'(err0), 8'd4);
        checkOutput("t2_pass", 8'(pass0), 8'd0);
        checkOutput("t2_err_w1_sat", 8'(err1), 8'd1);
        checkOutput("t2_pass_w1", 8'(pass1), 8'd0);
`ifdef GATE_SEQ_ERRLOG_EN
        checkOutput("t2_fe_vld", 8'(feVld0), 8'd1);
        checkOutput("t2_fe_idx", 8'(feIdx0), 8'd0);
`endif
        tick(1);

        $display("[TB] test 3: y stuck at 1");
        yMode = 2;
        applyStimulus(0);
        checkOutput("t3_err_clr", 8'(err0), 8'd0);
        tick(19);
        checkOutput("t3_err_e19", 8'(err0), 8'd0);
        tick(1);
        checkOutput("t3_done", 8'(done0), 8'd1);
        checkOutput("t3_err", 8'(err0), 8'd1);
        checkOutput("t3_pass", 8'(pass0), 8'd0);
        checkOutput("t3_err_w1", 8'(err1), 8'd1);
`ifdef GATE_SEQ_ERRLOG_EN
        checkOutput("t3_fe_idx", 8'(feIdx0), 8'd3);
`endif
        tick(1);
        checkOutput("t3_err_idle_hold", 8'(err0), 8'd1);

        $display("[TB] test 4: stray starts and exp_tt change mid-run");
        yMode = 0;
        baseCnt = doneCnt0;
        applyStimulus(0);
        expTt = 4'b1000;
        tick(6);
        start01 = 1'b1;
        tick(1);
        start01 = 1'b0;
        checkOutput("t4_busy_e7", 8'(busy0), 8'd1);
        checkOutput("t4_vec_e7", 8'(vec0), 8'd1);
        tick(12);
        checkOutput("t4_busy_e19", 8'(busy0), 8'd1);
        checkOutput("t4_done_e19", 8'(done0), 8'd0);
        tick(1);
        checkOutput("t4_done_e20", 8'(done0), 8'd1);
        checkOutput("t4_pass", 8'(pass0), 8'd1);
        start01 = 1'b1;
        tick(1);
        start01 = 1'b0;
        checkOutput("t4_done_e21", 8'(done0), 8'd0);
        checkOutput("t4_busy_e21", 8'(busy0), 8'd0);
        tick(1);
        checkOutput("t4_busy_e22", 8'(busy0), 8'd0);
        checkOutput("t4_done_count", 8'(doneCnt0 - baseCnt), 8'd1);
        expTt = 4'b0111;

        $display("[TB] test 5: reset mid-run");
        applyStimulus(0);
        tick(10);
        checkOutput("t5_ab_e10", 8'({a0, b0}), 8'd2);
        baseCnt = doneCnt0;
        rstN = 1'b0;
        #1;
        checkOutput("t5_rst_a", 8'(a0), 8'd0);
        checkOutput("t5_rst_b", 8'(b0), 8'd0);
        checkOutput("t5_rst_busy", 8'(busy0), 8'd0);
        checkOutput("t5_rst_err", 8'(err0), 8'd0);
        checkOutput("t5_rst_vec", 8'(vec0), 8'd0);
        tick(3);
        @(negedge clk) rstN = 1'b1;
        tick(1);
        checkOutput("t5_no_done", 8'(doneCnt0 - baseCnt), 8'd0);
        checkOutput("t5_idle_busy", 8'(busy0), 8'd0);
        applyStimulus(0);
        tick(19);
        checkOutput("t5_done_e19", 8'(done0), 8'd0);
        tick(1);
        checkOutput("t5_done_e20", 8'(done0), 8'd1);
        checkOutput("t5_pass", 8'(pass0), 8'd1);
        tick(1);

        $display("[TB] test 6: HOLD_CYCLES=1");
        applyStimulus(2);
        checkOutput("t6_ab_e0", 8'({a2, b2}), 8'd0);
        tick(2);
        checkOutput("t6_ab_e2", 8'({a2, b2}), 8'd1);
        checkOutput("t6_vec_e2", 8'(vec2), 8'd1);
        tick(2);
        checkOutput("t6_ab_e4", 8'({a2, b2}), 8'd2);
        tick(3);
        checkOutput("t6_busy_e7", 8'(busy2), 8'd1);
        checkOutput("t6_done_e7", 8'(done2), 8'd0);
        tick(1);
        checkOutput("t6_done_e8", 8'(done2), 8'd1);
        checkOutput("t6_pass", 8'(pass2), 8'd1);
        checkOutput("t6_err", 8'(err2), 8'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Hardware truth-table sequencer for a 2-input logic gate such as nand_gate.
- Drives the gate inputs a/b through all four vectors (00, 01, 10, 11) in order.
- Waits a programmable settle time per vector, samples the gate output y, and compares it against a 4-bit expected truth table.
- Sits beside a gate instance as an on-chip self-check controller and reports pass/fail with a start/busy/done handshake.

Parameters:
- HOLD_CYCLES, 4: settle cycles per vector before sampling y; legal range ≥1.
- CNT_W, 3: width of the mismatch counter; legal range ≥1; counter saturates.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE.
- exp_tt  input  4  expected y per vector; exp_tt[{a,b}] is the expected value.
- y  input  1  output of the gate under control.
- a  output  1  gate input a (registered).
- b  output  1  gate input b (registered).
- vec_idx  output  2  current vector index, equal to {a,b} while busy.
- busy  output  1  high from the start acceptance edge until the DONE transition.
- done  output  1  single-cycle completion pulse.
- pass  output  1  high when the last run had zero mismatches; held until the next start.
- err_cnt  output  CNT_W  mismatch count of the current or last run.

Behaviour:
- Reset (async assert, sync release): state=IDLE, a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, hold counter=0.
- Reset mid-run aborts immediately. No done pulse is issued; a fresh start is required.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1: latch exp_tt into tt_q, clear err_cnt and pass, set vec_idx=0, a=0, b=0, busy=1, load hold counter with HOLD_CYCLES-1, go to SETTLE.
- SETTLE:
  - If hold counter ≠0: decrement and stay.
  - If hold counter =0: go to SAMPLE.
- SAMPLE (one cycle):
  - Compare y with tt_q[vec_idx].
  - On mismatch, increment err_cnt, saturating at 2^CNT_W-1.
  - If vec_idx<3: increment vec_idx, drive {a,b}=vec_idx+1, reload hold counter, go to SETTLE.
  - If vec_idx=3: drive a=0, b=0, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 if the final err_cnt (including the last compare) is 0.
  - Go to IDLE next edge; done returns to 0.
- Timing:
  - Vector k is applied after edge k·(HOLD_CYCLES+1) relative to the start-accept edge 0.
  - y is sampled at edge (k+1)·(HOLD_CYCLES+1), giving HOLD_CYCLES+1 cycles of settle.
  - done is high for the cycle following edge 4·(HOLD_CYCLES+1); with default HOLD_CYCLES=4, done is visible after edge 20.
- start is ignored in SETTLE, SAMPLE and DONE; a start coincident with the done cycle is dropped.
- A start held high continuously re-runs back-to-back, with one IDLE cycle between runs.
- exp_tt changes during a run have no effect (tt_q is used). y is treated as synchronous to clk.
- err_cnt and pass hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro: GATE_SEQ_ERRLOG_EN.
- Defined:
  - Adds output first_err_vld (1 bit) and output first_err_idx (2 bits).
  - Both reset to 0 and are cleared on start acceptance.
  - On the first mismatch of a run: first_err_vld=1 and first_err_idx=vec_idx. Later mismatches do not overwrite these values.
- Undefined: ports and logic are absent, and the rest of the behaviour is identical.

Test Plan:
1. HOLD_CYCLES=4, exp_tt=4'b0111, y=~(a&b) (NAND), start pulse at edge 0 → a/b step 00,01,10,11 every 5 cycles; done after edge 20; pass=1; err_cnt=0; first_err_vld=0.
2. exp_tt=4'b0111, y=a&b → err_cnt=4, pass=0, first_err_vld=1, first_err_idx=0.
3. exp_tt=4'b0111, y stuck at 1 → err_cnt=1, pass=0, first_err_idx=3; CNT_W=1 variant with y=a&b → err_cnt saturates at 1.
4. Extra start pulses at edge 7 and during the done cycle → ignored; exactly one done pulse (after edge 20); busy stays 1 through edge 19.
5. rst_n driven low at cycle 10 → a, b, busy, err_cnt, vec_idx are 0 immediately (asynchronous), with no done pulse; after release, a new start completes with done after edge 20.
6. HOLD_CYCLES=1, NAND y, exp_tt=4'b0111 → each vector lasts 2 cycles; done after edge 8; pass=1.
